// File: rtl/xbar_rsp_track.sv
// Request crossbar with per-slave round-robin arbitration, response routing
// FIFOs and a decode-error pseudo-slave. Masters keep responses in order by
// only issuing further requests to the slave they are already waiting on.
module xbar_rsp_track #(
  parameter int unsigned DATA_WIDTH        = 32,
  parameter int unsigned MASTER_ADDR_WIDTH = 12,
  parameter int unsigned SLAVE_ADDR_WIDTH  = 10,
  parameter int unsigned MASTERS           = 4,
  parameter int unsigned SLAVES            = 3,
  parameter logic [SLAVES*MASTER_ADDR_WIDTH-1:0] ADDR_MATCH = {12'h800, 12'h400, 12'h000},
  parameter logic [SLAVES*MASTER_ADDR_WIDTH-1:0] ADDR_MASK  = {12'hC00, 12'hC00, 12'hC00},
  parameter int unsigned OSTD              = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [MASTERS-1:0]                m_req_i,
  input  logic [MASTERS*MASTER_ADDR_WIDTH-1:0] m_addr_i,
  input  logic [MASTERS-1:0]                m_we_i,
  input  logic [MASTERS*DATA_WIDTH/8-1:0]   m_be_i,
  input  logic [MASTERS*DATA_WIDTH-1:0]     m_wdata_i,
  output logic [MASTERS-1:0]                m_gnt_o,
  output logic [MASTERS-1:0]                m_rvalid_o,
  output logic [MASTERS*DATA_WIDTH-1:0]     m_rdata_o,
  output logic [MASTERS-1:0]                m_err_o,
  output logic [SLAVES-1:0]                 s_req_o,
  output logic [SLAVES*SLAVE_ADDR_WIDTH-1:0] s_addr_o,
  output logic [SLAVES-1:0]                 s_we_o,
  output logic [SLAVES*DATA_WIDTH/8-1:0]    s_be_o,
  output logic [SLAVES*DATA_WIDTH-1:0]      s_wdata_o,
  input  logic [SLAVES-1:0]                 s_gnt_i,
  input  logic [SLAVES-1:0]                 s_rvalid_i,
  input  logic [SLAVES*DATA_WIDTH-1:0]      s_rdata_i
);

  localparam int unsigned BW = DATA_WIDTH / 8;
  localparam int unsigned MW = (MASTERS > 1) ? $clog2(MASTERS) : 1;
  localparam int unsigned TW = $clog2(SLAVES + 1);
  localparam int unsigned PW = $clog2(OSTD);
  localparam int unsigned CW = $clog2(OSTD + 1);

  // Target index SLAVES denotes the decode-error pseudo-slave.
  logic [TW-1:0] dec      [MASTERS];
  logic [MASTERS-1:0] elig;
  logic [MW-1:0] win      [SLAVES+1];
  logic [SLAVES:0] has_win;
  logic [SLAVES:0] acc;
  logic [SLAVES:0] blocked;
  logic [SLAVES:0] gnt_ext;
  logic [SLAVES-1:0] pop;

  logic [MW-1:0] ptr_q    [SLAVES+1];
  logic [MW-1:0] fifo_q   [SLAVES][OSTD];
  logic [PW-1:0] rd_q     [SLAVES];
  logic [PW-1:0] wr_q     [SLAVES];
  logic [CW-1:0] fcnt_q   [SLAVES];
  logic [CW-1:0] cnt_q    [MASTERS];
  logic [TW-1:0] tgt_q    [MASTERS];
  logic          err_pend_q;
  logic [MW-1:0] err_mst_q;

  // Address decode and per-master eligibility (in-order response guarantee).
  always_comb begin
    for (int m = 0; m < MASTERS; m++) begin
      dec[m] = TW'(SLAVES);
      for (int s = SLAVES - 1; s >= 0; s--) begin
        if ((m_addr_i[m*MASTER_ADDR_WIDTH +: MASTER_ADDR_WIDTH] &
             ADDR_MASK[s*MASTER_ADDR_WIDTH +: MASTER_ADDR_WIDTH]) ==
            ADDR_MATCH[s*MASTER_ADDR_WIDTH +: MASTER_ADDR_WIDTH]) begin
          dec[m] = TW'(s);
        end
      end
      elig[m] = !rst && m_req_i[m] &&
                ((cnt_q[m] == '0) || ((cnt_q[m] < CW'(OSTD)) && (dec[m] == tgt_q[m])));
    end
  end

  // Round-robin arbitration per target, starting at that target's pointer.
  always_comb begin
    int idx;
    idx = 0;
    // The error pseudo-slave drains its pending entry every cycle, so it never blocks.
    blocked[SLAVES] = 1'b0;
    for (int s = 0; s < SLAVES; s++) begin
      blocked[s] = (fcnt_q[s] == CW'(OSTD));
      pop[s]     = !rst && s_rvalid_i[s] && (fcnt_q[s] != '0);
    end
    gnt_ext = {1'b1, s_gnt_i};
    for (int t = 0; t <= SLAVES; t++) begin
      has_win[t] = 1'b0;
      win[t]     = '0;
      if (!blocked[t]) begin
        for (int i = 0; i < MASTERS; i++) begin
          idx = (int'(ptr_q[t]) + i) % int'(MASTERS);
          if (!has_win[t] && elig[idx] && (dec[idx] == TW'(t))) begin
            has_win[t] = 1'b1;
            win[t]     = MW'(idx);
          end
        end
      end
      acc[t] = has_win[t] && gnt_ext[t];
    end
  end

  // Forward the winning request to each slave and return grants to masters.
  always_comb begin
    s_req_o   = '0;
    s_addr_o  = '0;
    s_we_o    = '0;
    s_be_o    = '0;
    s_wdata_o = '0;
    m_gnt_o   = '0;
    for (int s = 0; s < SLAVES; s++) begin
      if (has_win[s]) begin
        s_req_o[s] = 1'b1;
        s_addr_o[s*SLAVE_ADDR_WIDTH +: SLAVE_ADDR_WIDTH] =
          m_addr_i[int'(win[s])*MASTER_ADDR_WIDTH +: SLAVE_ADDR_WIDTH];
        s_we_o[s] = m_we_i[win[s]];
        s_be_o[s*BW +: BW] = m_be_i[int'(win[s])*BW +: BW];
        s_wdata_o[s*DATA_WIDTH +: DATA_WIDTH] = m_wdata_i[int'(win[s])*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    for (int t = 0; t <= SLAVES; t++) begin
      if (acc[t]) m_gnt_o[win[t]] = 1'b1;
    end
  end

  // Route slave responses and decode-error responses back to masters.
  always_comb begin
    m_rvalid_o = '0;
    m_rdata_o  = '0;
    m_err_o    = '0;
    if (!rst && err_pend_q) begin
      m_rvalid_o[err_mst_q] = 1'b1;
      m_err_o[err_mst_q]    = 1'b1;
    end
    for (int s = 0; s < SLAVES; s++) begin
      if (pop[s]) begin
        m_rvalid_o[fifo_q[s][rd_q[s]]] = 1'b1;
        m_rdata_o[int'(fifo_q[s][rd_q[s]])*DATA_WIDTH +: DATA_WIDTH] =
          s_rdata_i[s*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Pointers, routing FIFOs, outstanding counters and error pending register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int t = 0; t <= SLAVES; t++) ptr_q[t] <= '0;
      for (int s = 0; s < SLAVES; s++) begin
        rd_q[s]   <= '0;
        wr_q[s]   <= '0;
        fcnt_q[s] <= '0;
      end
      for (int m = 0; m < MASTERS; m++) begin
        cnt_q[m] <= '0;
        tgt_q[m] <= '0;
      end
      err_pend_q <= 1'b0;
      err_mst_q  <= '0;
    end else begin
      for (int t = 0; t <= SLAVES; t++) begin
        if (acc[t]) ptr_q[t] <= (win[t] == MW'(MASTERS - 1)) ? '0 : win[t] + MW'(1);
      end
      for (int s = 0; s < SLAVES; s++) begin
        if (acc[s]) begin
          fifo_q[s][wr_q[s]] <= win[s];
          wr_q[s] <= wr_q[s] + PW'(1);
        end
        if (pop[s]) rd_q[s] <= rd_q[s] + PW'(1);
        case ({acc[s], pop[s]})
          2'b10:   fcnt_q[s] <= fcnt_q[s] + CW'(1);
          2'b01:   fcnt_q[s] <= fcnt_q[s] - CW'(1);
          default: fcnt_q[s] <= fcnt_q[s];
        endcase
      end
      err_pend_q <= acc[SLAVES];
      err_mst_q  <= win[SLAVES];
      for (int m = 0; m < MASTERS; m++) begin
        case ({m_gnt_o[m], m_rvalid_o[m]})
          2'b10:   cnt_q[m] <= cnt_q[m] + CW'(1);
          2'b01:   cnt_q[m] <= cnt_q[m] - CW'(1);
          default: cnt_q[m] <= cnt_q[m];
        endcase
        if (m_gnt_o[m]) tgt_q[m] <= dec[m];
      end
    end
  end

endmodule

// File: tb/tb_xbar_rsp_track.sv
// Directed bench for xbar_rsp_track with default parameters.
module tb_xbar_rsp_track;
  localparam int unsigned DW = 32;
  localparam int unsigned MAW = 12;
  localparam int unsigned SAW = 10;
  localparam int unsigned NM = 4;
  localparam int unsigned NS = 3;
  localparam int unsigned BW = DW / 8;

  logic clk = 1'b0;
  logic rst;
  logic [NM-1:0]     m_req;
  logic [NM*MAW-1:0] m_addr;
  logic [NM-1:0]     m_we;
  logic [NM*BW-1:0]  m_be;
  logic [NM*DW-1:0]  m_wdata;
  logic [NM-1:0]     m_gnt_o;
  logic [NM-1:0]     m_rvalid_o;
  logic [NM*DW-1:0]  m_rdata_o;
  logic [NM-1:0]     m_err_o;
  logic [NS-1:0]     s_req_o;
  logic [NS*SAW-1:0] s_addr_o;
  logic [NS-1:0]     s_we_o;
  logic [NS*BW-1:0]  s_be_o;
  logic [NS*DW-1:0]  s_wdata_o;
  logic [NS-1:0]     s_gnt;
  logic [NS-1:0]     s_rvalid;
  logic [NS*DW-1:0]  s_rdata;

  int checks = 0;
  int errors = 0;
  logic [NM-1:0] exp_m;

  always #5 clk = ~clk;

  xbar_rsp_track dut (
    .clk(clk), .rst(rst),
    .m_req_i(m_req), .m_addr_i(m_addr), .m_we_i(m_we), .m_be_i(m_be), .m_wdata_i(m_wdata),
    .m_gnt_o(m_gnt_o), .m_rvalid_o(m_rvalid_o), .m_rdata_o(m_rdata_o), .m_err_o(m_err_o),
    .s_req_o(s_req_o), .s_addr_o(s_addr_o), .s_we_o(s_we_o), .s_be_o(s_be_o), .s_wdata_o(s_wdata_o),
    .s_gnt_i(s_gnt), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all_addr(input logic [MAW-1:0] a);
    for (int m = 0; m < NM; m++) m_addr[m*MAW +: MAW] = a;
  endtask

  initial begin
    rst = 1'b1;
    m_req = '1; m_we = '0; m_be = '1; m_wdata = '0;
    set_all_addr(12'h404);
    s_gnt = '1; s_rvalid = 3'b111; s_rdata = '0;
    #1;
    chk("rst_sreq", 128'(s_req_o), 128'(0));
    chk("rst_gnt", 128'(m_gnt_o), 128'(0));
    chk("rst_rvalid", 128'(m_rvalid_o), 128'(0));
    step(); step();

    // Round-robin on slave 1 with in-order response routing.
    rst = 1'b0;
    s_gnt = 3'b010; s_rvalid = '0;
    m_we = 4'b0100;
    m_wdata[2*DW +: DW] = 32'hDEADBEEF;
    for (int k = 0; k < 5; k++) begin
      s_rvalid = (k >= 1) ? 3'b010 : 3'b000;
      #1;
      exp_m = 4'(1 << (k % 4));
      chk("rr_gnt", 128'(m_gnt_o), 128'(exp_m));
      chk("rr_sreq", 128'(s_req_o), 128'(3'b010));
      chk("rr_saddr", 128'(s_addr_o), 128'(30'h0000_1000));
      if (k >= 1) begin
        exp_m = 4'(1 << (k - 1));
        chk("rr_route", 128'(m_rvalid_o), 128'(exp_m));
      end
      if (k == 2) begin
        chk("rr_we", 128'(s_we_o), 128'(3'b010));
        chk("rr_wdata", 128'(s_wdata_o[DW +: DW]), 128'(32'hDEADBEEF));
      end
      step();
    end
    m_req = '0; m_we = '0;
    #1;
    chk("rr_drain", 128'(m_rvalid_o), 128'(4'b0001));
    step();
    s_rvalid = '0;
    #1;
    chk("idle_gnt", 128'(m_gnt_o), 128'(0));
    chk("idle_rvalid", 128'(m_rvalid_o), 128'(0));
    chk("idle_err", 128'(m_err_o), 128'(0));
    chk("idle_rdata", m_rdata_o, 128'(0));

    // Master 2 switching slaves must wait for its outstanding read.
    s_gnt = 3'b011;
    m_req = 4'b0100;
    m_addr[2*MAW +: MAW] = 12'h000;
    #1;
    chk("sw_gnt0", 128'(m_gnt_o), 128'(4'b0100));
    chk("sw_sreq0", 128'(s_req_o), 128'(3'b001));
    step();
    m_addr[2*MAW +: MAW] = 12'h404;
    #1;
    chk("sw_stall1", 128'(m_gnt_o), 128'(0));
    chk("sw_stall_sreq", 128'(s_req_o), 128'(0));
    step();
    #1;
    chk("sw_stall2", 128'(m_gnt_o), 128'(0));
    step();
    s_rvalid = 3'b001;
    s_rdata[0 +: DW] = 32'h0000_0055;
    #1;
    chk("sw_rvalid", 128'(m_rvalid_o), 128'(4'b0100));
    chk("sw_rdata", 128'(m_rdata_o[2*DW +: DW]), 128'(32'h55));
    chk("sw_stall3", 128'(m_gnt_o), 128'(0));
    step();
    s_rvalid = '0;
    #1;
    chk("sw_gnt1", 128'(m_gnt_o), 128'(4'b0100));
    chk("sw_sreq1", 128'(s_req_o), 128'(3'b010));
    step();
    m_req = '0;
    s_rvalid = 3'b010;
    #1;
    chk("sw_drain", 128'(m_rvalid_o), 128'(4'b0100));
    step();
    s_rvalid = '0;

    // Decode error on master 1.
    m_req = 4'b0010;
    m_addr[1*MAW +: MAW] = 12'hC10;
    #1;
    chk("de_gnt", 128'(m_gnt_o), 128'(4'b0010));
    chk("de_sreq", 128'(s_req_o), 128'(0));
    step();
    m_req = '0;
    #1;
    chk("de_rvalid", 128'(m_rvalid_o), 128'(4'b0010));
    chk("de_err", 128'(m_err_o), 128'(4'b0010));
    chk("de_rdata", m_rdata_o, 128'(0));
    step();
    #1;
    chk("de_done", 128'(m_rvalid_o | m_err_o), 128'(0));

    // Outstanding limit: four reads fill slave 0, the fifth waits.
    s_gnt = 3'b001;
    m_req = 4'b0001;
    m_addr[0 +: MAW] = 12'h008;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("full_gnt", 128'(m_gnt_o), 128'(4'b0001));
      step();
    end
    #1;
    chk("full_sreq", 128'(s_req_o), 128'(0));
    chk("full_gnt5", 128'(m_gnt_o), 128'(0));
    step();
    s_rvalid = 3'b001;
    s_rdata[0 +: DW] = 32'h11;
    #1;
    chk("full_rv", 128'(m_rvalid_o), 128'(4'b0001));
    chk("full_sreq2", 128'(s_req_o), 128'(0));
    step();
    s_rvalid = '0;
    #1;
    chk("full_free", 128'(s_req_o), 128'(3'b001));
    chk("full_gnt6", 128'(m_gnt_o), 128'(4'b0001));
    step();
    m_req = '0;
    s_rvalid = 3'b001;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("full_drain", 128'(m_rvalid_o), 128'(4'b0001));
      step();
    end
    s_rvalid = '0;
    #1;
    chk("full_empty", 128'(m_rvalid_o), 128'(0));

    // Interleaved masters 0 and 3 on slave 2.
    s_gnt = 3'b100;
    m_req = 4'b1001;
    m_addr[0 +: MAW] = 12'h800;
    m_addr[3*MAW +: MAW] = 12'h800;
    #1;
    chk("il_g0", 128'(m_gnt_o), 128'(4'b0001));
    step();
    #1;
    chk("il_g1", 128'(m_gnt_o), 128'(4'b1000));
    step();
    #1;
    chk("il_g2", 128'(m_gnt_o), 128'(4'b0001));
    step();
    m_req = '0;
    s_rvalid = 3'b100;
    s_rdata[2*DW +: DW] = 32'hA;
    #1;
    chk("il_rv0", 128'(m_rvalid_o), 128'(4'b0001));
    chk("il_rd0", 128'(m_rdata_o[0 +: DW]), 128'(32'hA));
    step();
    s_rdata[2*DW +: DW] = 32'hB;
    #1;
    chk("il_rv1", 128'(m_rvalid_o), 128'(4'b1000));
    chk("il_rd1", 128'(m_rdata_o[3*DW +: DW]), 128'(32'hB));
    step();
    s_rdata[2*DW +: DW] = 32'hC;
    #1;
    chk("il_rv2", 128'(m_rvalid_o), 128'(4'b0001));
    chk("il_rd2", 128'(m_rdata_o[0 +: DW]), 128'(32'hC));
    step();
    s_rvalid = '0;

    // Reset with three reads outstanding on slave 0.
    s_gnt = 3'b001;
    m_req = 4'b0010;
    m_addr[1*MAW +: MAW] = 12'h010;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("rs_gnt", 128'(m_gnt_o), 128'(4'b0010));
      step();
    end
    rst = 1'b1;
    s_rvalid = 3'b001;
    #1;
    chk("rs_sreq", 128'(s_req_o), 128'(0));
    chk("rs_gntz", 128'(m_gnt_o), 128'(0));
    chk("rs_rvz", 128'(m_rvalid_o), 128'(0));
    step();
    rst = 1'b0;
    m_req = '0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("rs_stray", 128'(m_rvalid_o), 128'(0));
      step();
    end
    s_rvalid = '0;
    m_req = 4'b1111;
    set_all_addr(12'h000);
    #1;
    chk("rs_restart", 128'(m_gnt_o), 128'(4'b0001));
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
